// File: rtl/lsm_sequencer.sv
// lsm_sequencer: load/store-multiple register-list sequencer.
// Latches an IR register list on LOAD, walks it lowest-first with SCAN/CONSUME,
// and reports the transfer count plus start and writeback byte offsets.
// Optional build macro: LSM_WB_CALC_EN enables the writeback offset (WB_OFS);
// without it WB_OFS is tied to zero and no writeback arithmetic exists.
module lsm_sequencer (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        LSM_EN,
    input  logic [2:0]  LSM_IN,
    input  logic [31:0] IR,
    output logic        LSM_DETECT,
    output logic        LSM_END,
    output logic [3:0]  REG_NUM,
    output logic [4:0]  REG_CNT,
    output logic [7:0]  START_OFS,
    output logic [7:0]  WB_OFS
);

    localparam int unsigned LIST_W = 16;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned OFS_W  = 8;

    localparam logic [2:0] CMD_LOAD    = 3'b001;
    localparam logic [2:0] CMD_SCAN    = 3'b010;
    localparam logic [2:0] CMD_CONSUME = 3'b011;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACTIVE = 2'b01,
        DONE   = 2'b10
    } state_t;

    state_t              state;
    logic [LIST_W-1:0]   pm;
    logic [CNT_W-1:0]    ir_cnt;
    logic [3:0]          low_idx;
    logic [LIST_W-1:0]   pm_cleared;
    logic [OFS_W-1:0]    four_n;
    logic [OFS_W-1:0]    start_ofs_c;
    logic                ir_p;
    logic                ir_u;
    logic                unused_ir;

    assign ir_p      = IR[24];
    assign ir_u      = IR[23];
    assign unused_ir = ^{IR[31:25], IR[22:16]};

    // Popcount of the incoming register list.
    always_comb begin
        ir_cnt = '0;
        for (int i = 0; i < LIST_W; i++) begin
            ir_cnt = ir_cnt + CNT_W'(IR[i]);
        end
    end

    // Index of the lowest pending register (priority from bit 0).
    always_comb begin
        low_idx = '0;
        for (int i = LIST_W - 1; i >= 0; i--) begin
            if (pm[i]) begin
                low_idx = 4'(i);
            end
        end
    end

    // Pending mask with the currently selected register retired.
    assign pm_cleared = pm & ~(LIST_W'(1) << REG_NUM);

    // 4*n as an 8-bit quantity; n <= 16 so the result never exceeds 64.
    assign four_n = {1'b0, ir_cnt, 2'b00};

    // Start offset for the four addressing modes; an empty list starts at base.
    always_comb begin
        start_ofs_c = '0;
        if (ir_cnt != '0) begin
            unique case ({ir_p, ir_u})
                2'b01:   start_ofs_c = 8'h00;
                2'b11:   start_ofs_c = 8'h04;
                2'b00:   start_ofs_c = 8'h04 - four_n;
                default: start_ofs_c = 8'h00 - four_n;
            endcase
        end
    end

    // Sequencer state, pending mask and all registered outputs.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state      <= IDLE;
            pm         <= '0;
            LSM_DETECT <= 1'b0;
            LSM_END    <= 1'b0;
            REG_NUM    <= '0;
            REG_CNT    <= '0;
            START_OFS  <= '0;
`ifdef LSM_WB_CALC_EN
            WB_OFS     <= '0;
`endif
        end else if (LSM_EN) begin
            case (LSM_IN)
                CMD_LOAD: begin
                    state      <= ACTIVE;
                    pm         <= IR[LIST_W-1:0];
                    LSM_DETECT <= 1'b0;
                    LSM_END    <= 1'b0;
                    REG_NUM    <= '0;
                    REG_CNT    <= ir_cnt;
                    START_OFS  <= start_ofs_c;
`ifdef LSM_WB_CALC_EN
                    WB_OFS     <= ir_u ? four_n : (8'h00 - four_n);
`endif
                end
                CMD_SCAN: begin
                    if (state == ACTIVE) begin
                        if (pm != '0) begin
                            REG_NUM    <= low_idx;
                            LSM_DETECT <= 1'b1;
                            LSM_END    <= 1'b0;
                        end else begin
                            LSM_DETECT <= 1'b0;
                            LSM_END    <= 1'b1;
                            state      <= DONE;
                        end
                    end
                end
                CMD_CONSUME: begin
                    if (state == ACTIVE && LSM_DETECT) begin
                        pm         <= pm_cleared;
                        LSM_DETECT <= 1'b0;
                        if (pm_cleared == '0) begin
                            LSM_END <= 1'b1;
                            state   <= DONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifndef LSM_WB_CALC_EN
    // Writeback offset disabled in this build.
    assign WB_OFS = '0;
`endif

endmodule

// File: tb/tb_lsm_sequencer.sv
// Directed self-checking bench for lsm_sequencer.
module tb_lsm_sequencer;

    logic        CLK;
    logic        RESET;
    logic        LSM_EN;
    logic [2:0]  LSM_IN;
    logic [31:0] IR;
    logic        LSM_DETECT;
    logic        LSM_END;
    logic [3:0]  REG_NUM;
    logic [4:0]  REG_CNT;
    logic [7:0]  START_OFS;
    logic [7:0]  WB_OFS;

    int checks = 0;
    int errors = 0;

`ifdef LSM_WB_CALC_EN
    localparam bit WB_EN = 1'b1;
`else
    localparam bit WB_EN = 1'b0;
`endif

    localparam logic [2:0] NOP  = 3'b000;
    localparam logic [2:0] LOAD = 3'b001;
    localparam logic [2:0] SCAN = 3'b010;
    localparam logic [2:0] CONS = 3'b011;

    // Output word layout: det[26] end[25] num[24:21] cnt[20:16] start[15:8] wb[7:0]
    localparam logic [26:0] NO_NUM = 27'h61FFFFF;

    lsm_sequencer dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .LSM_EN     (LSM_EN),
        .LSM_IN     (LSM_IN),
        .IR         (IR),
        .LSM_DETECT (LSM_DETECT),
        .LSM_END    (LSM_END),
        .REG_NUM    (REG_NUM),
        .REG_CNT    (REG_CNT),
        .START_OFS  (START_OFS),
        .WB_OFS     (WB_OFS)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [26:0] outs();
        return {LSM_DETECT, LSM_END, REG_NUM, REG_CNT, START_OFS, WB_OFS};
    endfunction

    function automatic logic [26:0] pk(input logic det, input logic fin, input logic [3:0] num,
                                       input logic [4:0] cnt, input logic [7:0] st, input logic [7:0] wb);
        return {det, fin, num, cnt, st, (WB_EN ? wb : 8'h00)};
    endfunction

    // Every cycle: DETECT and END are mutually exclusive.
    always @(negedge CLK) begin
        checks++;
        if (LSM_DETECT && LSM_END) begin
            errors++;
            $display("FAIL det_end_exclusive at %0t: both asserted", $time);
        end
    end

    // Drive one command for one clock; sample #1 after the edge.
    task automatic cmd(input logic en, input logic [2:0] c, input logic [31:0] ir);
        @(negedge CLK);
        LSM_EN = en;
        LSM_IN = c;
        IR     = ir;
        @(posedge CLK);
        #1;
        LSM_EN = 1'b0;
        LSM_IN = NOP;
    endtask

    task automatic test_reset();
        logic [26:0] exp;
        RESET = 1'b0; LSM_EN = 1'b0; LSM_IN = NOP; IR = 32'hFFFF_FFFF;
        repeat (2) @(posedge CLK);
        #1;
        exp = pk(0, 0, 0, 0, 8'h00, 8'h00);
        checks++;
        if (outs() !== exp) begin errors++; $display("FAIL reset_state got=%h exp=%h", outs(), exp); end
        @(negedge CLK);
        RESET = 1'b1;
        cmd(1, SCAN, 32'hFFFF_FFFF);
        cmd(1, CONS, 32'hFFFF_FFFF);
        checks++;
        if (outs() !== exp) begin errors++; $display("FAIL idle_ignores_cmds got=%h exp=%h", outs(), exp); end
    endtask

    task automatic test_ia_walk();
        logic [26:0] exp;
        logic [3:0]  nums [3] = '{4'd0, 4'd2, 4'd15};
        cmd(1, LOAD, 32'h0080_8005);
        exp = pk(0, 0, 0, 5'd3, 8'h00, 8'h0C);
        checks++;
        if ((outs() & NO_NUM) !== (exp & NO_NUM)) begin errors++; $display("FAIL ia_load got=%h exp=%h", outs(), exp); end
        for (int i = 0; i < 3; i++) begin
            cmd(1, SCAN, 32'h0000_FFFF);
            exp = pk(1, 0, nums[i], 5'd3, 8'h00, 8'h0C);
            checks++;
            if (outs() !== exp) begin errors++; $display("FAIL ia_scan%0d got=%h exp=%h", i, outs(), exp); end
            cmd(1, CONS, 32'h0000_FFFF);
            exp = pk(0, (i == 2), nums[i], 5'd3, 8'h00, 8'h0C);
            checks++;
            if (outs() !== exp) begin errors++; $display("FAIL ia_consume%0d got=%h exp=%h", i, outs(), exp); end
        end
        cmd(1, SCAN, 32'h0000_FFFF);
        cmd(1, CONS, 32'h0000_FFFF);
        checks++;
        if (outs() !== exp) begin errors++; $display("FAIL done_holds got=%h exp=%h", outs(), exp); end
    endtask

    task automatic test_modes();
        logic [26:0] exp;
        cmd(1, LOAD, 32'h0100_FFFF);
        exp = pk(0, 0, 0, 5'd16, 8'hC0, 8'hC0);
        checks++;
        if ((outs() & NO_NUM) !== (exp & NO_NUM)) begin errors++; $display("FAIL db_full_load got=%h exp=%h", outs(), exp); end
        cmd(1, SCAN, 32'h0);
        exp = pk(1, 0, 0, 5'd16, 8'hC0, 8'hC0);
        checks++;
        if (outs() !== exp) begin errors++; $display("FAIL db_scan got=%h exp=%h", outs(), exp); end
        cmd(1, LOAD, 32'h0000_000F);
        exp = pk(0, 0, 0, 5'd4, 8'hF4, 8'hF0);
        checks++;
        if ((outs() & NO_NUM) !== (exp & NO_NUM)) begin errors++; $display("FAIL da_load got=%h exp=%h", outs(), exp); end
        cmd(1, LOAD, 32'h0180_0003);
        exp = pk(0, 0, 0, 5'd2, 8'h04, 8'h08);
        checks++;
        if ((outs() & NO_NUM) !== (exp & NO_NUM)) begin errors++; $display("FAIL ib_load got=%h exp=%h", outs(), exp); end
    endtask

    task automatic test_empty_list();
        logic [26:0] exp;
        cmd(1, LOAD, 32'h0000_0000);
        exp = pk(0, 0, 0, 5'd0, 8'h00, 8'h00);
        checks++;
        if ((outs() & NO_NUM) !== (exp & NO_NUM)) begin errors++; $display("FAIL empty_load got=%h exp=%h", outs(), exp); end
        cmd(1, SCAN, 32'hFFFF_FFFF);
        exp = {1'b0, 1'b1, REG_NUM, 5'd0, 8'h00, 8'h00};
        checks++;
        if ((outs() & NO_NUM) !== (exp & NO_NUM)) begin errors++; $display("FAIL empty_scan_end got=%h exp=%h", outs(), exp); end
        exp = outs();
        cmd(1, CONS, 32'hFFFF_FFFF);
        cmd(1, SCAN, 32'hFFFF_FFFF);
        checks++;
        if ((outs() & NO_NUM) !== (exp & NO_NUM) || LSM_END !== 1'b1) begin errors++; $display("FAIL empty_done_holds got=%h exp=%h", outs(), exp); end
    endtask

    task automatic test_async_reset();
        logic [26:0] exp;
        cmd(1, LOAD, 32'h0180_0003);
        cmd(1, SCAN, 32'h0);
        exp = pk(1, 0, 0, 5'd2, 8'h04, 8'h08);
        checks++;
        if (outs() !== exp) begin errors++; $display("FAIL pre_reset_scan got=%h exp=%h", outs(), exp); end
        #2;
        RESET = 1'b0;
        #1;
        exp = pk(0, 0, 0, 0, 8'h00, 8'h00);
        checks++;
        if (outs() !== exp) begin errors++; $display("FAIL async_reset got=%h exp=%h", outs(), exp); end
        @(negedge CLK);
        RESET = 1'b1;
        cmd(1, SCAN, 32'h0);
        cmd(1, CONS, 32'h0);
        checks++;
        if (outs() !== exp) begin errors++; $display("FAIL post_reset_idle got=%h exp=%h", outs(), exp); end
    endtask

    task automatic test_reload();
        logic [26:0] exp;
        cmd(1, LOAD, 32'h0080_00F0);
        exp = pk(0, 0, 0, 5'd4, 8'h00, 8'h10);
        checks++;
        if ((outs() & NO_NUM) !== (exp & NO_NUM)) begin errors++; $display("FAIL reload_first got=%h exp=%h", outs(), exp); end
        cmd(1, CONS, 32'hFFFF_FFFF);
        checks++;
        if ((outs() & NO_NUM) !== (exp & NO_NUM) || LSM_DETECT !== 1'b0) begin errors++; $display("FAIL consume_no_detect got=%h exp=%h", outs(), exp); end
        cmd(1, SCAN, 32'hFFFF_FFFF);
        exp = pk(1, 0, 4'd4, 5'd4, 8'h00, 8'h10);
        checks++;
        if (outs() !== exp) begin errors++; $display("FAIL reload_scan4 got=%h exp=%h", outs(), exp); end
        cmd(1, LOAD, 32'h0080_0100);
        exp = pk(0, 0, 0, 5'd1, 8'h00, 8'h04);
        checks++;
        if ((outs() & NO_NUM) !== (exp & NO_NUM)) begin errors++; $display("FAIL reload_second got=%h exp=%h", outs(), exp); end
        cmd(1, SCAN, 32'h0000_FFFF);
        exp = pk(1, 0, 4'd8, 5'd1, 8'h00, 8'h04);
        checks++;
        if (outs() !== exp) begin errors++; $display("FAIL reload_scan8 got=%h exp=%h", outs(), exp); end
        cmd(1, CONS, 32'h0000_FFFF);
        exp = pk(0, 1, 4'd8, 5'd1, 8'h00, 8'h04);
        checks++;
        if (outs() !== exp) begin errors++; $display("FAIL reload_consume_end got=%h exp=%h", outs(), exp); end
    endtask

    task automatic test_hold();
        logic [26:0] exp;
        logic [2:0]  codes [5] = '{3'b000, 3'b100, 3'b101, 3'b110, 3'b111};
        cmd(1, LOAD, 32'h0080_0300);
        cmd(1, SCAN, 32'h0);
        exp = pk(1, 0, 4'd8, 5'd2, 8'h00, 8'h08);
        checks++;
        if (outs() !== exp) begin errors++; $display("FAIL hold_setup got=%h exp=%h", outs(), exp); end
        for (int i = 0; i < 4; i++) begin
            cmd(0, 3'(i), $urandom());
            checks++;
            if (outs() !== exp) begin errors++; $display("FAIL hold_en0_%0d got=%h exp=%h", i, outs(), exp); end
        end
        for (int i = 0; i < 5; i++) begin
            cmd(1, codes[i], $urandom());
            checks++;
            if (outs() !== exp) begin errors++; $display("FAIL hold_code%0d got=%h exp=%h", i, outs(), exp); end
        end
        cmd(1, CONS, 32'h0);
        cmd(1, SCAN, 32'h0);
        exp = pk(1, 0, 4'd9, 5'd2, 8'h00, 8'h08);
        checks++;
        if (outs() !== exp) begin errors++; $display("FAIL hold_resume got=%h exp=%h", outs(), exp); end
    endtask

    initial begin
        test_reset();
        test_ia_walk();
        test_modes();
        test_empty_list();
        test_async_reset();
        test_reload();
        test_hold();
        repeat (2) @(posedge CLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
